// File: rtl/memory_access_stage_pkg.sv
// Payload types shared between Execute, the memory access stage and Writeback.
package memory_access_stage_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        mem_op_e     memOp;
        logic [31:0] data;
        logic [31:0] storeData;
        logic [4:0]  destinationRegister;
        logic        writebackEnable;
        csr_op_e     CSROp;
        logic [31:0] oldCSRValue;
        logic [11:0] destinationCSR;
        logic        CSRWriteIntent;
    } executeMemoryPayload_;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] data;
        logic [4:0]  destinationRegister;
        logic        writebackEnable;
        csr_op_e     CSROp;
        logic [31:0] oldCSRValue;
        logic [11:0] destinationCSR;
        logic        CSRWriteIntent;
    } memoryWritebackPayload_;

endpackage

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: issues single-outstanding loads/stores on the
// data bus, aligns load data and registers the payload handed to Writeback.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  executeMemoryPayload_   executeMemoryPayload,
    output logic                   memoryStall,
    output logic                   dataReq,
    output logic                   dataWe,
    output logic [31:0]            dataAddr,
    output logic [31:0]            dataWdata,
    output logic [3:0]             dataBe,
    input  logic                   dataAck,
    input  logic [31:0]            dataRdata,
    output memoryWritebackPayload_ memoryWritebackPayload
);

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0]  count_q, count_d;
    executeMemoryPayload_      pend_q, pend_d;
    memoryWritebackPayload_    wb_q, wb_d;

    executeMemoryPayload_      src_c;
    logic [3:0]                be_c;
    logic [31:0]               wdata_c;
    logic                      issue_c;

    function automatic logic is_store(input mem_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        logic bad;
        case (op)
            LH, LHU, SH: bad = off[0];
            LW, SW:      bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic memoryWritebackPayload_ pass_through(input executeMemoryPayload_ p);
        memoryWritebackPayload_ w;
        w.valid               = p.valid;
        w.illegal             = p.illegal;
        w.data                = p.data;
        w.destinationRegister = p.destinationRegister;
        w.writebackEnable     = p.writebackEnable;
        w.CSROp               = p.CSROp;
        w.oldCSRValue         = p.oldCSRValue;
        w.destinationCSR      = p.destinationCSR;
        w.CSRWriteIntent      = p.CSRWriteIntent;
        return w;
    endfunction

    function automatic logic [31:0] align_load(input mem_op_e op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = rdata >> {off, 3'b000};
        case (op)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     result = {24'h000000, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     result = {16'h0000, shifted[15:0]};
            default: result = rdata;
        endcase
        return result;
    endfunction

    function automatic memoryWritebackPayload_ complete(input executeMemoryPayload_ p,
                                                        input logic [31:0] rdata);
        memoryWritebackPayload_ w;
        w         = pass_through(p);
        w.valid   = 1'b1;
        w.illegal = 1'b0;
        if (is_store(p.memOp)) begin
            w.writebackEnable = 1'b0;
            w.data            = p.data;
        end else begin
            w.data = align_load(p.memOp, p.data[1:0], rdata);
        end
        return w;
    endfunction

    // Bus lane decode for the access being presented (latched copy while waiting).
    always_comb begin
        src_c = (state_q == WAIT) ? pend_q : executeMemoryPayload;
        case (src_c.memOp)
            LB, LBU, SB: be_c = 4'b0001 << src_c.data[1:0];
            LH, LHU, SH: be_c = 4'b0011 << src_c.data[1:0];
            LW, SW:      be_c = 4'b1111;
            default:     be_c = 4'b0000;
        endcase
        case (src_c.memOp)
            SB:      wdata_c = {4{src_c.storeData[7:0]}};
            SH:      wdata_c = {2{src_c.storeData[15:0]}};
            SW:      wdata_c = src_c.storeData;
            default: wdata_c = 32'h0000_0000;
        endcase
    end

    // Next-state, bus handshake and Writeback payload selection.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_d      = pend_q;
        wb_d        = '0;
        wb_d.CSROp  = CSR_NONE;
        issue_c     = 1'b0;
        memoryStall = 1'b0;
        dataReq     = 1'b0;
        dataWe      = 1'b0;
        dataAddr    = 32'h0000_0000;
        dataWdata   = 32'h0000_0000;
        dataBe      = 4'b0000;

        // Comb outputs stay quiet during reset even if upstream still presents an access.
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (!flush && src_c.valid) begin
                        if (src_c.illegal) begin
                            wb_d         = pass_through(src_c);
                            wb_d.illegal = 1'b1;
                        end else if (src_c.memOp == NONE) begin
                            wb_d = pass_through(src_c);
                        end else if (is_misaligned(src_c.memOp, src_c.data[1:0])) begin
                            wb_d                 = pass_through(src_c);
                            wb_d.valid           = 1'b1;
                            wb_d.illegal         = 1'b1;
                            wb_d.writebackEnable = 1'b0;
                        end else begin
                            issue_c = 1'b1;
                            if (dataAck) begin
                                wb_d = complete(src_c, dataRdata);
                            end else begin
                                memoryStall = 1'b1;
                                pend_d      = src_c;
                                count_d     = TIMEOUT_WIDTH'(1);
                                state_d     = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (count_q >= TIMEOUT_LIMIT) begin
                        wb_d                 = pass_through(pend_q);
                        wb_d.valid           = 1'b1;
                        wb_d.illegal         = 1'b1;
                        wb_d.writebackEnable = 1'b0;
                        state_d              = IDLE;
                        count_d              = '0;
                    end else begin
                        issue_c = 1'b1;
                        if (dataAck) begin
                            wb_d    = complete(pend_q, dataRdata);
                            state_d = IDLE;
                            count_d = '0;
                        end else begin
                            memoryStall = 1'b1;
                            count_d     = count_q + TIMEOUT_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (issue_c) begin
            dataReq   = 1'b1;
            dataWe    = is_store(src_c.memOp);
            dataAddr  = {src_c.data[31:2], 2'b00};
            dataWdata = wdata_c;
            dataBe    = be_c;
        end
    end

    // State, timeout counter, latched request and Writeback payload registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pend_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            wb_q    <= wb_d;
        end
    end

    assign memoryWritebackPayload = wb_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomised and directed bench for memory_access_stage against a behavioural model.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    localparam int TO = 4;

    logic                   clock;
    logic                   reset;
    logic                   flush;
    executeMemoryPayload_   em;
    logic                   memoryStall;
    logic                   dataReq;
    logic                   dataWe;
    logic [31:0]            dataAddr;
    logic [31:0]            dataWdata;
    logic [3:0]             dataBe;
    logic                   dataAck;
    logic [31:0]            dataRdata;
    memoryWritebackPayload_ wb;

    int n_checks;
    int n_fail;

    memory_access_stage #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_WIDTH (3)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .flush                 (flush),
        .executeMemoryPayload  (em),
        .memoryStall           (memoryStall),
        .dataReq               (dataReq),
        .dataWe                (dataWe),
        .dataAddr              (dataAddr),
        .dataWdata             (dataWdata),
        .dataBe                (dataBe),
        .dataAck               (dataAck),
        .dataRdata             (dataRdata),
        .memoryWritebackPayload(wb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic int m_size(input mem_op_e op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit m_store(input mem_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic bit m_misaligned(input mem_op_e op, input logic [31:0] addr);
        int sz;
        sz = m_size(op);
        return (sz > 1) && ((addr % sz) != 0);
    endfunction

    function automatic logic [3:0] m_be(input mem_op_e op, input logic [31:0] addr);
        int sz;
        sz = m_size(op);
        if (sz == 1) return 4'(32'd1 << (addr % 4));
        if (sz == 2) return 4'(32'd3 << (addr % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input mem_op_e op, input logic [31:0] sd);
        if (op == SB) return (sd % 256) * 32'h0101_0101;
        if (op == SH) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input mem_op_e op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        case (op)
            LB:  begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            LBU: v = v % 256;
            LH:  begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            LHU: v = v % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Presents one instruction, acks after d cycles (never if d >= TO), checks bus and result.
    task automatic run_op(input string tag, input mem_op_e op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdata, input int d,
                          input logic ill, output int stall_cnt, output int req_cnt);
        logic [4:0]  rd;
        logic        wbe;
        csr_op_e     cop;
        logic [31:0] ocsr;
        logic [11:0] dcsr;
        logic        cwi;
        logic [31:0] exp_data;
        logic        exp_ill, exp_wbe, exp_req, exp_stall;
        bit          check_data, bus;
        rd   = 5'($urandom);
        wbe  = 1'($urandom);
        cop  = csr_op_e'($urandom_range(0, 3));
        ocsr = $urandom;
        dcsr = 12'($urandom);
        cwi  = 1'($urandom);
        em.valid = 1'b1; em.illegal = ill; em.memOp = op; em.data = addr; em.storeData = sd;
        em.destinationRegister = rd; em.writebackEnable = wbe; em.CSROp = cop;
        em.oldCSRValue = ocsr; em.destinationCSR = dcsr; em.CSRWriteIntent = cwi;
        stall_cnt = 0;
        req_cnt   = 0;
        bus = !ill && (op != NONE) && !m_misaligned(op, addr);

        exp_ill = ill; exp_wbe = wbe; exp_data = addr; check_data = 1;
        if (!ill && op != NONE) begin
            if (m_misaligned(op, addr) || d >= TO) begin
                exp_ill = 1'b1; exp_wbe = 1'b0; check_data = 0;
            end else if (m_store(op)) begin
                exp_wbe = 1'b0;
            end else begin
                exp_data = m_load(op, addr, rdata);
            end
        end

        for (int c = 0; c <= TO; c++) begin
            dataAck   = bus && (c == d);
            dataRdata = (c == d) ? rdata : $urandom;
            #2;
            if (dataReq === 1'b1) req_cnt++;
            if (memoryStall === 1'b1) stall_cnt++;
            exp_req   = bus && (c < TO);
            exp_stall = bus && (c < TO) && (c != d);
            n_checks++;
            if (dataReq !== exp_req) begin
                n_fail++;
                $display("FAIL %s dataReq cycle %0d: got %b expected %b", tag, c, dataReq, exp_req);
            end
            n_checks++;
            if (memoryStall !== exp_stall) begin
                n_fail++;
                $display("FAIL %s memoryStall cycle %0d: got %b expected %b", tag, c, memoryStall, exp_stall);
            end
            if (exp_req) begin
                n_checks++;
                if (dataAddr !== {addr[31:2], 2'b00} || dataBe !== m_be(op, addr) ||
                    dataWe !== m_store(op)) begin
                    n_fail++;
                    $display("FAIL %s bus cycle %0d: got addr=%h be=%b we=%b expected addr=%h be=%b we=%b",
                             tag, c, dataAddr, dataBe, dataWe, {addr[31:2], 2'b00}, m_be(op, addr), m_store(op));
                end
                if (m_store(op)) begin
                    n_checks++;
                    if (dataWdata !== m_wdata(op, sd)) begin
                        n_fail++;
                        $display("FAIL %s dataWdata: got %h expected %h", tag, dataWdata, m_wdata(op, sd));
                    end
                end
            end
            @(posedge clock); #1;
            if (!bus || c == d || c == TO) break;
        end
        dataAck  = 1'b0;
        em.valid = 1'b0;

        n_checks++;
        if (wb.valid !== 1'b1 || wb.illegal !== exp_ill || wb.writebackEnable !== exp_wbe ||
            wb.destinationRegister !== rd) begin
            n_fail++;
            $display("FAIL %s payload: got v=%b ill=%b wbe=%b rd=%0d expected v=1 ill=%b wbe=%b rd=%0d",
                     tag, wb.valid, wb.illegal, wb.writebackEnable, wb.destinationRegister, exp_ill, exp_wbe, rd);
        end
        if (check_data) begin
            n_checks++;
            if (wb.data !== exp_data) begin
                n_fail++;
                $display("FAIL %s payload data: got %h expected %h", tag, wb.data, exp_data);
            end
        end
        if (op == NONE && !ill) begin
            n_checks++;
            if (wb.CSROp !== cop || wb.oldCSRValue !== ocsr || wb.destinationCSR !== dcsr ||
                wb.CSRWriteIntent !== cwi) begin
                n_fail++;
                $display("FAIL %s csr fields: got %0d %h %h %b expected %0d %h %h %b", tag,
                         wb.CSROp, wb.oldCSRValue, wb.destinationCSR, wb.CSRWriteIntent, cop, ocsr, dcsr, cwi);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; em = '0; dataAck = 1'b0; dataRdata = '0;
        #3;
        n_checks++;
        if (wb !== '0) begin
            n_fail++;
            $display("FAIL reset payload: got %h expected 0", wb);
        end
        n_checks++;
        if ({dataReq, dataWe, dataBe, dataAddr, dataWdata, memoryStall} !== '0) begin
            n_fail++;
            $display("FAIL reset bus: got req=%b we=%b be=%b addr=%h wdata=%h stall=%b expected all 0",
                     dataReq, dataWe, dataBe, dataAddr, dataWdata, memoryStall);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_alu();
        em = '0;
        em.valid = 1'b1; em.memOp = NONE; em.data = 32'h0000_1234;
        em.destinationRegister = 5'd5; em.writebackEnable = 1'b1;
        #2;
        n_checks++;
        if (memoryStall !== 1'b0 || dataReq !== 1'b0) begin
            n_fail++;
            $display("FAIL alu stall/req: got %b/%b expected 0/0", memoryStall, dataReq);
        end
        @(posedge clock); #1;
        em.valid = 1'b0;
        n_checks++;
        if (wb.valid !== 1'b1 || wb.data !== 32'h1234 || wb.destinationRegister !== 5'd5 ||
            wb.writebackEnable !== 1'b1 || wb.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL alu payload: got v=%b data=%h rd=%0d wbe=%b expected v=1 data=1234 rd=5 wbe=1",
                     wb.valid, wb.data, wb.destinationRegister, wb.writebackEnable);
        end
    endtask

    task automatic test_loads();
        int s, r;
        run_op("lb", LB, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 3, 1'b0, s, r);
        n_checks++;
        if (s != 3 || wb.data !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb stall/data: got %0d/%h expected 3/ffffff80", s, wb.data);
        end
        run_op("lbu", LBU, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 3, 1'b0, s, r);
        n_checks++;
        if (wb.data !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL lbu data: got %h expected 00000080", wb.data);
        end
        run_op("lw_same_cycle", LW, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 1'b0, s, r);
        n_checks++;
        if (s != 0 || wb.data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL lw same-cycle stall/data: got %0d/%h expected 0/cafef00d", s, wb.data);
        end
    endtask

    task automatic test_store();
        int s, r;
        run_op("sh", SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1, 1'b0, s, r);
        n_checks++;
        if (wb.writebackEnable !== 1'b0 || wb.data !== 32'h0000_2002) begin
            n_fail++;
            $display("FAIL sh payload: got wbe=%b data=%h expected 0/00002002", wb.writebackEnable, wb.data);
        end
    endtask

    task automatic test_misaligned();
        int s, r;
        run_op("lw_misaligned", LW, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0, s, r);
        n_checks++;
        if (r != 0 || wb.illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned req/illegal: got %0d/%b expected 0/1", r, wb.illegal);
        end
    endtask

    task automatic test_timeout();
        int s, r;
        run_op("timeout", LW, 32'h0000_5000, 32'h0, 32'h0, TO + 1, 1'b0, s, r);
        n_checks++;
        if (r != TO) begin
            n_fail++;
            $display("FAIL timeout req cycles: got %0d expected %0d", r, TO);
        end
        dataAck = 1'b1;
        #2;
        n_checks++;
        if (dataReq !== 1'b0 || memoryStall !== 1'b0) begin
            n_fail++;
            $display("FAIL stray ack bus: got req=%b stall=%b expected 0/0", dataReq, memoryStall);
        end
        @(posedge clock); #1;
        dataAck = 1'b0;
        n_checks++;
        if (wb.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray ack payload valid: got %b expected 0", wb.valid);
        end
    endtask

    task automatic test_flush();
        int s, r;
        em = '0;
        em.valid = 1'b1; em.memOp = LW; em.data = 32'h0000_4000; em.writebackEnable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        flush = 1'b1; dataAck = 1'b1; dataRdata = 32'h1111_2222;
        #2;
        n_checks++;
        if (dataReq !== 1'b0) begin
            n_fail++;
            $display("FAIL flush dataReq: got %b expected 0", dataReq);
        end
        @(posedge clock); #1;
        flush = 1'b0; dataAck = 1'b0; em.valid = 1'b0;
        n_checks++;
        if (wb.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush payload valid: got %b expected 0", wb.valid);
        end
        #2;
        n_checks++;
        if (dataReq !== 1'b0) begin
            n_fail++;
            $display("FAIL post-flush dataReq: got %b expected 0", dataReq);
        end
        @(posedge clock); #1;
        run_op("after_flush", NONE, 32'h0000_0042, 32'h0, 32'h0, 0, 1'b0, s, r);
    endtask

    task automatic test_reset_mid_wait();
        int s, r;
        em = '0;
        em.valid = 1'b1; em.memOp = SW; em.data = 32'h0000_6000; em.storeData = 32'h5555_AAAA;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (dataReq !== 1'b0 || memoryStall !== 1'b0 || wb.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset mid-wait: got req=%b stall=%b valid=%b expected 0/0/0",
                     dataReq, memoryStall, wb.valid);
        end
        em.valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        run_op("after_reset", LHU, 32'h0000_7002, 32'h0, 32'hBEEF_0000, 2, 1'b0, s, r);
    endtask

    task automatic test_random();
        int s, r;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                em.valid = 1'b0; em.memOp = SW;
                #2;
                n_checks++;
                if (dataReq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bubble %0d dataReq: got %b expected 0", i, dataReq);
                end
                @(posedge clock); #1;
                n_checks++;
                if (wb.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bubble %0d payload valid: got %b expected 0", i, wb.valid);
                end
            end
            run_op($sformatf("rand%0d", i), mem_op_e'($urandom_range(0, 8)), $urandom, $urandom,
                   $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 9) == 0), s, r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu();
        test_loads();
        test_store();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage between Execute and Writeback; registers the memoryWritebackPayload_ consumed by Writeback.
- Performs loads and stores over a single-outstanding data-bus request/acknowledge handshake.
- Aligns and extends load data, flags misaligned accesses and bus timeouts as illegal, and stalls upstream while a bus transaction is pending.
- Non-memory instructions (ALU results, CSR ops) pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for dataAck before the access is aborted as illegal.
- TIMEOUT_WIDTH, 8: width of the timeout counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kill the instruction in this stage (trap/redirect); highest priority after reset.
- executeMemoryPayload  in  struct  executeMemoryPayload_; fields used: valid, illegal, memOp (NONE/LB/LH/LW/LBU/LHU/SB/SH/SW), data (ALU result, also the address), storeData[31:0], destinationRegister[4:0], writebackEnable, CSROp, oldCSRValue, destinationCSR, CSRWriteIntent.
- memoryStall  out  1  upstream must hold executeMemoryPayload stable while high.
- dataReq  out  1  bus request; held high until dataAck.
- dataWe  out  1  store when high.
- dataAddr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dataWdata  out  32  store data replicated into lanes: SB {4{b}}, SH {2{h}}, SW word.
- dataBe  out  4  byte enables; SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
- dataAck  in  1  single-cycle completion pulse.
- dataRdata  in  32  load data; valid in the cycle dataAck is high.
- memoryWritebackPayload  out  struct  memoryWritebackPayload_ registered to Writeback.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; payload.valid=0, illegal=0, data=0, writebackEnable=0, CSROp=CSR_NONE, all other payload fields 0; dataReq=0, dataWe=0, dataBe=0, dataAddr=0, dataWdata=0; memoryStall=0; timeout counter=0.
- States: IDLE, WAIT.
- IDLE, input valid and legal, memOp=NONE: next edge registers the payload, passing through valid, illegal, destinationRegister, data, writebackEnable and the CSR fields. One-cycle latency, no stall.
- IDLE, input valid, memOp≠NONE, aligned: combinationally drive dataReq=1 with dataAddr, dataBe, dataWe and dataWdata; memoryStall=1 unless dataAck arrives the same cycle. Without a same-cycle ack, go to WAIT and latch the request signals. Output payload.valid=0 while waiting (bubble).
- Misaligned access: LH, LHU or SH with addr[0]=1, or LW or SW with addr[1:0]≠0. Issue no bus request; register the payload with valid=1, illegal=1, writebackEnable=0.
- Input already illegal: pass it through with illegal=1 and issue no bus request.
- WAIT: dataReq held at 1 with latched signals stable; memoryStall=1; the counter increments every cycle.
- WAIT, dataAck=1: next edge registers the payload with valid=1 and returns to IDLE; memoryStall=0 in the ack cycle.
  - Loads: data = lane select on addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
  - Stores: writebackEnable=0 and data=address.
- Counter reaching TIMEOUT_CYCLES without ack: drop dataReq, register illegal=1, valid=1, return to IDLE. A late ack in IDLE is ignored.
- flush=1: next edge payload.valid=0 and the state returns to IDLE.
  - In WAIT, dataReq is deasserted immediately and the outstanding ack is ignored.
  - A store that has already been acked is not undone.
- flush takes priority over a same-cycle dataAck.
- Input valid=0: register a bubble (payload.valid=0); no bus activity.
- Only one request is outstanding at a time; a new request cannot issue in the cycle an ack retires unless the state is IDLE and the next instruction is presented.

Test Plan:
- ALU pass-through: addi result 0x1234, rd=5, writebackEnable=1 -> next cycle payload valid=1, data=0x1234, destinationRegister=5; memoryStall never high.
- LB at 0x1003, ack after 3 cycles with rdata 0x80FFFFFF -> dataBe=1000, memoryStall high for 3 cycles, payload data=0xFFFFFF80; LBU same access -> 0x00000080.
- SH at 0x2002 with storeData 0xABCD -> dataWe=1, dataBe=1100, dataWdata=0xABCDABCD, dataAddr=0x2000; payload writebackEnable=0.
- LW at 0x3001 -> no dataReq; payload valid=1, illegal=1, writebackEnable=0.
- LW with no ack, TIMEOUT_CYCLES=4 -> dataReq high exactly 4 cycles, then payload illegal=1, state IDLE, later stray ack ignored.
- flush asserted in WAIT together with dataAck, and reset pulled low mid-WAIT -> payload.valid=0, dataReq=0 immediately (reset asynchronously), next instruction processes normally.
